// File: rtl/pwm_fade_ch_if.sv
// Configuration and output bundle for pwm_fade_ch.
//
// Signals:
//   wr_en     write strobe for one channel configuration
//   wr_ch     target channel index
//   wr_duty   duty value (static) or fade ceiling (breathe)
//   wr_mode   0 = static duty, 1 = breathe (triangle fade)
//   wr_ready  write accepted this cycle when high
//   led       registered PWM outputs, bit i = channel i
//
// Modports: master drives the write side, slave is the PWM block.
interface pwm_fade_ch_if #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4
);
  localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                wr_en;
  logic [CH_W-1:0]     wr_ch;
  logic [WIDTH-1:0]    wr_duty;
  logic                wr_mode;
  logic                wr_ready;
  logic [CHANNELS-1:0] led;

  modport master (
    output wr_en,
    output wr_ch,
    output wr_duty,
    output wr_mode,
    input  wr_ready,
    input  led
  );

  modport slave (
    input  wr_en,
    input  wr_ch,
    input  wr_duty,
    input  wr_mode,
    output wr_ready,
    output led
  );
endinterface

// File: rtl/pwm_fade_ch.sv
// Multi-channel PWM generator with optional triangle "breathe" fade per channel.
//
// A shared period counter runs 0..PERIOD-1 (PERIOD = 2^WIDTH - 1). Each channel
// compares it against an active duty (act) to produce a registered output.
// Writes land in a shadow register (shd) and only reach act on the period
// boundary, so the waveform of the period in flight is never disturbed.
// In breathe mode act walks up to shd and back down to 0, one step every
// STEP_DIV periods.
//
// Ports:
//   clk  sole clock, rising edge
//   rst  asynchronous, active-high reset
//   bus  pwm_fade_ch_if.slave: wr_en/wr_ch/wr_duty/wr_mode in, wr_ready/led out
module pwm_fade_ch #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned STEP_DIV = 16
) (
  input logic          clk,
  input logic          rst,
  pwm_fade_ch_if.slave bus
);

  localparam int unsigned PERIOD = (1 << WIDTH) - 1;
  localparam int unsigned PD_W   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [WIDTH-1:0] CntLast  = WIDTH'(PERIOD - 1);
  localparam logic [PD_W-1:0]  PdivLast = PD_W'(STEP_DIV - 1);

  typedef enum logic {
    ModeStatic  = 1'b0,
    ModeBreathe = 1'b1
  } mode_e;

  typedef enum logic {
    DirUp   = 1'b0,
    DirDown = 1'b1
  } dir_e;

  // Shared timing
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [PD_W-1:0]  pdiv_q, pdiv_d;

  // Per-channel state
  logic [WIDTH-1:0] act_q  [CHANNELS];
  logic [WIDTH-1:0] act_d  [CHANNELS];
  logic [WIDTH-1:0] shd_q  [CHANNELS];
  logic [WIDTH-1:0] shd_d  [CHANNELS];
  mode_e            mode_q [CHANNELS];
  mode_e            mode_d [CHANNELS];
  dir_e             dir_q  [CHANNELS];
  dir_e             dir_d  [CHANNELS];

  logic [CHANNELS-1:0] led_q, led_d;

  logic        boundary;
  logic        tick;
  logic        wr_ready;
  logic        wr_accept;
  int unsigned wr_ch_idx;
  mode_e       wr_mode_e;

  // Shared period counter and step divider.
  always_comb begin
    boundary = (cnt_q == CntLast);
    tick     = boundary && (pdiv_q == PdivLast);
    cnt_d    = boundary ? '0 : cnt_q + 1'b1;
    pdiv_d   = pdiv_q;
    if (boundary) begin
      pdiv_d = (pdiv_q == PdivLast) ? '0 : pdiv_q + 1'b1;
    end
  end

  // Writes are refused on the last count so a shadow update can never race
  // the boundary transfer into act.
  always_comb begin
    wr_ready  = !boundary;
    wr_ch_idx = 32'(bus.wr_ch);
    wr_mode_e = mode_e'(bus.wr_mode);
    wr_accept = bus.wr_en && wr_ready && (wr_ch_idx < CHANNELS);
  end

  // Per-channel next state.
  always_comb begin
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      shd_d[i]  = shd_q[i];
      mode_d[i] = mode_q[i];
      dir_d[i]  = dir_q[i];
      act_d[i]  = act_q[i];
      led_d[i]  = (cnt_q < act_q[i]);

      if (wr_accept && (wr_ch_idx == i)) begin
        shd_d[i]  = bus.wr_duty;
        mode_d[i] = wr_mode_e;
        // Switching mode restarts the fade on an upward ramp.
        if (wr_mode_e != mode_q[i]) begin
          dir_d[i] = DirUp;
        end
      end

      // Writes never coincide with the boundary, so these assignments do not
      // collide with the write path above.
      if (boundary) begin
        if (mode_q[i] == ModeStatic) begin
          act_d[i] = shd_q[i];
        end else if (tick) begin
          if (dir_q[i] == DirUp) begin
            if (act_q[i] < shd_q[i]) begin
              act_d[i] = act_q[i] + 1'b1;
            end else begin
              // At or above the ceiling (ceiling may have been lowered).
              dir_d[i] = DirDown;
              act_d[i] = (shd_q[i] != '0) ? shd_q[i] - 1'b1 : '0;
            end
          end else begin
            if (act_q[i] != '0) begin
              act_d[i] = act_q[i] - 1'b1;
            end else begin
              dir_d[i] = DirUp;
              act_d[i] = (shd_q[i] != '0) ? WIDTH'(1) : '0;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      pdiv_q <= '0;
      led_q  <= '0;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        act_q[i]  <= '0;
        shd_q[i]  <= '0;
        mode_q[i] <= ModeStatic;
        dir_q[i]  <= DirUp;
      end
    end else begin
      cnt_q  <= cnt_d;
      pdiv_q <= pdiv_d;
      led_q  <= led_d;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        act_q[i]  <= act_d[i];
        shd_q[i]  <= shd_d[i];
        mode_q[i] <= mode_d[i];
        dir_q[i]  <= dir_d[i];
      end
    end
  end

  assign bus.wr_ready = wr_ready;
  assign bus.led      = led_q;

endmodule

// File: doc/pwm_fade_ch.md
PWM_FADE_CH -- requirements
Module: pwm_fade_ch

Interface
REQ-001 Parameter WIDTH, 8, counter and duty width in bits (WIDTH >= 2).
REQ-002 Parameter CHANNELS, 4, number of independent PWM outputs (CHANNELS >= 1).
REQ-003 Parameter STEP_DIV, 16, PWM periods per breathe step (STEP_DIV >= 1).
REQ-004 Derived constants: PERIOD = 2^WIDTH - 1 clocks; CH_W = max(1, clog2(CHANNELS)).
REQ-005 clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 wr_en  in  1  write strobe for one channel configuration.
REQ-008 wr_ch  in  CH_W  target channel index.
REQ-009 wr_duty  in  WIDTH  duty value (static) or ceiling value (breathe).
REQ-010 wr_mode  in  1  0 = static duty, 1 = breathe (triangle fade).
REQ-011 wr_ready  out  1  write accepted this cycle when high.
REQ-012 led  out  CHANNELS  registered PWM outputs, bit i = channel i.

Function
REQ-013 Period counter cnt SHALL count 0..PERIOD-1 and wrap to 0; "boundary edge" = the edge where cnt goes PERIOD-1 -> 0.
REQ-014 led[i] SHALL be registered as (cnt < act[i]); led lags cnt by exactly one cycle.
REQ-015 act[i] = 0 SHALL hold led[i] low constantly; act[i] = PERIOD SHALL hold it high constantly.
REQ-016 wr_ready SHALL be combinationally low when cnt == PERIOD-1 and high otherwise.
REQ-017 A write SHALL be accepted when wr_en && wr_ready && wr_ch < CHANNELS; it loads shd[wr_ch] <= wr_duty and mode[wr_ch] <= wr_mode.
REQ-018 Writes with wr_ready low or wr_ch >= CHANNELS SHALL be ignored with no state change.
REQ-019 A write whose wr_mode differs from the channel's current mode SHALL also set dir[wr_ch] <= up.
REQ-020 Active values SHALL change only on boundary edges; mid-period writes never alter the current period's waveform.
REQ-021 Static channel: at each boundary edge act[i] <= shd[i].
REQ-022 Step divider pdiv SHALL count boundary edges 0..STEP_DIV-1 and wrap; a step tick is a boundary edge with pdiv == STEP_DIV-1.
REQ-023 Breathe channel: act[i] is unchanged on non-tick boundary edges.
REQ-024 Breathe tick, dir up, act < shd: act <= act+1.
REQ-025 Breathe tick, dir up, act >= shd: dir <= down, act <= (shd > 0 ? shd-1 : 0).
REQ-026 Breathe tick, dir down, act > 0: act <= act-1.
REQ-027 Breathe tick, dir down, act == 0: dir <= up, act <= (shd > 0 ? 1 : 0).
REQ-028 With shd == 0 in breathe mode, act SHALL stay 0.
REQ-029 All act arithmetic SHALL stay within 0..PERIOD without wrap.
REQ-030 Channels SHALL be fully independent apart from sharing cnt and pdiv.

Reset
REQ-031 rst high SHALL immediately, without a clock edge, force cnt = 0, pdiv = 0, all act/shd = 0, mode = static, dir = up, led = 0.
REQ-032 wr_ready SHALL read 1 during and immediately after reset (cnt = 0).
REQ-033 Reset asserted mid-period or mid-fade SHALL discard all configuration; operation restarts from cnt = 0 on the first edge after release.

Verification (WIDTH=4, PERIOD=15, CHANNELS=2, STEP_DIV=2)
REQ-034 Reset: rst pulsed between edges -> led = 00 at once, wr_ready = 1; with no writes, led stays 00 for 3 periods.
REQ-035 Static: write ch0 duty 5, mode 0 at cnt = 3 -> current period unchanged; from the next period led[0] high exactly 5 of every 15 cycles, rising the cycle after cnt == 0.
REQ-036 Extremes: ch0 duty 0 and ch1 duty 15 -> after the next boundary led[0] constant 0, led[1] constant 1 across 2 full periods.
REQ-037 Handshake: wr_en high at cnt = 14 with duty 9 -> wr_ready = 0, write ignored, led duty unchanged; the same write at cnt = 0 is accepted.
REQ-038 Breathe: ch1 duty 3, mode 1 -> act[1] at successive ticks (every 2 periods) = 1,2,3,2,1,0,1,2; led[1] high-time per period equals the act in force.
REQ-039 Async reset during breathe with act[1] = 2 -> led = 00 immediately; after release act[1] = 0, mode static.
